// File: rtl/alu_mul_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_ctrl_pkg
//  Description : Shared definitions for the ALU-based sequential multiplier.
//                Provides the Hack ALU control words (zx nx zy ny f no), the
//                datapath widths and the controller state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_ctrl_pkg;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 4;

    // Control word bit order: [5]=zx [4]=nx [3]=zy [2]=ny [1]=f [0]=no
    localparam logic [5:0] ALU_ADD    = 6'b000010;
    localparam logic [5:0] ALU_PASS_X = 6'b001100;
    localparam logic [5:0] ALU_ZERO   = 6'b101010;

    // Last iteration index: 16 multiplier bits processed.
    localparam logic [CNT_W-1:0] CNT_LAST = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DBL  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/alu_mul_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mul_seq_if
//  Description : Start/done coprocessor handshake for the sequential
//                multiplier.
//                master : drives start, a, b; observes status and result.
//                slave  : the multiplier side.
//                Signals: start, a[15:0], b[15:0]  -> multiplier
//                         ready, busy, done, product[15:0], zr, ng <- multiplier
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_mul_seq_if;
    import alu_ctrl_pkg::*;

    logic              start;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              ready;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] product;
    logic              zr;
    logic              ng;

    modport master (
        output start, a, b,
        input  ready, busy, done, product, zr, ng
    );

    modport slave (
        input  start, a, b,
        output ready, busy, done, product, zr, ng
    );

endinterface
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
//  Module      : alu
//  Description : Hack ALU, purely combinational.
//                x_i, y_i [15:0] : operands
//                ctrl_i   [5:0]  : {zx, nx, zy, ny, f, no}
//                out_o    [15:0] : result
//                zr_o            : out_o == 0
//                ng_o            : out_o[15]
//  Revision    : 1.0 - initial release
// ============================================================================
module alu
    import alu_ctrl_pkg::*;
(
    input  wire logic [DATA_W-1:0] x_i,
    input  wire logic [DATA_W-1:0] y_i,
    input  wire logic [5:0]        ctrl_i,
    output logic      [DATA_W-1:0] out_o,
    output logic                   zr_o,
    output logic                   ng_o
);

    logic [DATA_W-1:0] x_z;
    logic [DATA_W-1:0] x_n;
    logic [DATA_W-1:0] y_z;
    logic [DATA_W-1:0] y_n;
    logic [DATA_W-1:0] f_out;

    always_comb begin
        x_z   = ctrl_i[5] ? '0 : x_i;
        x_n   = ctrl_i[4] ? ~x_z : x_z;
        y_z   = ctrl_i[3] ? '0 : y_i;
        y_n   = ctrl_i[2] ? ~y_z : y_z;
        f_out = ctrl_i[1] ? (x_n + y_n) : (x_n & y_n);
        out_o = ctrl_i[0] ? ~f_out : f_out;
        zr_o  = (out_o == '0);
        ng_o  = out_o[DATA_W-1];
    end

endmodule
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mul_seq
//  Description : Shift-and-add 16x16 -> 16 multiplier built around a single
//                Hack ALU. Every addition and every doubling of the
//                multiplicand is an ALU ADD; the final zr/ng flags come from
//                an ALU PASS_X of the accumulator.
//                clk     : system clock, rising edge
//                rst_n   : synchronous active-low reset
//                mul_if  : slave side of the start/done handshake
//                          (start, a, b in; ready, busy, done, product, zr,
//                          ng out)
//                EARLY_EXIT = 1 stops once the remaining multiplier bits are
//                zero; 0 gives a fixed 33-cycle operation.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_seq
    import alu_ctrl_pkg::*;
#(
    parameter bit EARLY_EXIT = 1'b1
)(
    input  wire logic     clk,
    input  wire logic     rst_n,
    alu_mul_seq_if.slave  mul_if
);

    state_e             state_q;
    logic [DATA_W-1:0]  acc_q;
    logic [DATA_W-1:0]  mcand_q;
    logic [DATA_W-1:0]  mplier_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [DATA_W-1:0]  product_q;
    logic               zr_q;
    logic               ng_q;

    logic [DATA_W-1:0]  alu_x;
    logic [DATA_W-1:0]  alu_y;
    logic [5:0]         alu_ctrl;
    logic [DATA_W-1:0]  alu_out;
    logic               alu_zr;
    logic               alu_ng;

    // Operand/control mux: the ALU's job is fixed by the current state.
    always_comb begin
        alu_x    = '0;
        alu_y    = '0;
        alu_ctrl = ALU_ZERO;
        case (state_q)
            IDLE: begin
                alu_x    = product_q;
                alu_ctrl = ALU_PASS_X;
            end
            ADD: begin
                alu_x    = acc_q;
                alu_y    = mcand_q;
                alu_ctrl = ALU_ADD;
            end
            DBL: begin
                // x + x is the left shift; the carry out of bit 15 is lost.
                alu_x    = mcand_q;
                alu_y    = mcand_q;
                alu_ctrl = ALU_ADD;
            end
            DONE: begin
                alu_x    = acc_q;
                alu_ctrl = ALU_PASS_X;
            end
            default: begin
                alu_ctrl = ALU_ZERO;
            end
        endcase
    end

    alu u_alu (
        .x_i    (alu_x),
        .y_i    (alu_y),
        .ctrl_i (alu_ctrl),
        .out_o  (alu_out),
        .zr_o   (alu_zr),
        .ng_o   (alu_ng)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            zr_q      <= 1'b0;
            ng_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mul_if.start) begin
                        acc_q    <= '0;
                        mcand_q  <= mul_if.a;
                        mplier_q <= mul_if.b;
                        cnt_q    <= '0;
                        state_q  <= ADD;
                    end
                end
                ADD: begin
                    if (mplier_q[0]) begin
                        acc_q <= alu_out;
                    end
                    state_q <= DBL;
                end
                DBL: begin
                    mcand_q  <= alu_out;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 4'd1;
                    // Early exit looks at the multiplier as it will be after
                    // this shift, so the last set bit is always processed.
                    if ((cnt_q == CNT_LAST) ||
                        (EARLY_EXIT && (mplier_q[DATA_W-1:1] == '0))) begin
                        state_q <= DONE;
                    end else begin
                        state_q <= ADD;
                    end
                end
                DONE: begin
                    product_q <= acc_q;
                    zr_q      <= alu_zr;
                    ng_q      <= alu_ng;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mul_if.ready   = (state_q == IDLE);
    assign mul_if.busy    = (state_q != IDLE);
    assign mul_if.done    = (state_q == DONE);
    assign mul_if.product = product_q;
    assign mul_if.zr      = zr_q;
    assign mul_if.ng      = ng_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_mul_seq
//  Description : Self-checking bench for alu_mul_seq. Two instances (early
//                exit on and off) share one stimulus stream. A transaction
//                level model (product = a*b, latency from the multiplier's
//                top bit) predicts every output on every cycle; directed
//                cases pin the model with literal values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_mul_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;

    int n_checks;
    int n_fail;

    alu_mul_seq_if u_if1 ();
    alu_mul_seq_if u_if0 ();

    assign u_if1.start = start;
    assign u_if1.a     = a;
    assign u_if1.b     = b;
    assign u_if0.start = start;
    assign u_if0.a     = a;
    assign u_if0.b     = b;

    alu_mul_seq #(.EARLY_EXIT(1'b1)) dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .mul_if (u_if1)
    );

    alu_mul_seq #(.EARLY_EXIT(1'b0)) dut0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .mul_if (u_if0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: index 1 = early exit, index 0 = fixed latency.
    // m_cnt = busy cycles still to come (0 = idle, 1 = done cycle).
    // ------------------------------------------------------------------
    function automatic int lat_of(logic [15:0] bv, bit ee);
        int n;
        if (!ee) return 33;
        n = 1;
        for (int i = 0; i < 16; i++) begin
            if (bv[i]) n = i + 1;
        end
        return 2 * n + 1;
    endfunction

    int          m_cnt  [2];
    logic [15:0] m_pend [2];
    logic [15:0] m_prod [2];
    logic        m_zr   [2];
    logic        m_ng   [2];
    logic        m_valid = 1'b0;

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_cnt[d]  <= 0;
                m_prod[d] <= 16'h0;
                m_zr[d]   <= 1'b0;
                m_ng[d]   <= 1'b0;
            end else if (m_cnt[d] == 0) begin
                if (start) begin
                    m_cnt[d]  <= lat_of(b, d == 1);
                    m_pend[d] <= a * b;
                end
            end else begin
                m_cnt[d] <= m_cnt[d] - 1;
                if (m_cnt[d] == 1) begin
                    m_prod[d] <= m_pend[d];
                    m_zr[d]   <= (m_pend[d] == 16'h0);
                    m_ng[d]   <= m_pend[d][15];
                end
            end
        end
        if (!rst_n) m_valid <= 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            check("cycle_ee1",
                  {11'h0, u_if1.ready, u_if1.busy, u_if1.done, u_if1.zr, u_if1.ng, u_if1.product},
                  {11'h0, m_cnt[1] == 0, m_cnt[1] != 0, m_cnt[1] == 1, m_zr[1], m_ng[1], m_prod[1]});
            check("cycle_ee0",
                  {11'h0, u_if0.ready, u_if0.busy, u_if0.done, u_if0.zr, u_if0.ng, u_if0.product},
                  {11'h0, m_cnt[0] == 0, m_cnt[0] != 0, m_cnt[0] == 1, m_zr[0], m_ng[0], m_prod[0]});
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all input changes happen on the falling edge)
    // ------------------------------------------------------------------
    task automatic wait_ready();
        for (int k = 0; k < 60; k++) begin
            if (u_if1.ready && u_if0.ready) break;
            @(negedge clk);
        end
        check("wait_ready", {30'h0, u_if1.ready, u_if0.ready}, 32'h3);
    endtask

    task automatic run_op(input logic [15:0] ai, input logic [15:0] bi,
                          input logic [15:0] ep, input logic ez, input logic en,
                          input int el1, input int el0, input bit lit);
        int l1;
        int l0;
        l1 = 0;
        l0 = 0;
        wait_ready();
        start = 1'b1;
        a     = ai;
        b     = bi;
        @(negedge clk);
        start = 1'b0;
        a     = 16'($urandom);
        b     = 16'($urandom);
        for (int k = 1; k <= 40; k++) begin
            if (u_if1.done && l1 == 0) l1 = k;
            if (u_if0.done && l0 == 0) l0 = k;
            if (l1 != 0 && l0 != 0) break;
            @(negedge clk);
        end
        check("op_done_seen", {30'h0, l1 != 0, l0 != 0}, 32'h3);
        @(negedge clk);
        if (lit) begin
            check("lat_ee1", l1, el1);
            check("lat_ee0", l0, el0);
            check("prod_ee1", {16'h0, u_if1.product}, {16'h0, ep});
            check("prod_ee0", {16'h0, u_if0.product}, {16'h0, ep});
            check("flags_ee1", {30'h0, u_if1.zr, u_if1.ng}, {30'h0, ez, en});
        end
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int seen_done;
        int bits;
        n_checks = 0;
        n_fail   = 0;
        start    = 1'b0;
        a        = 16'h0;
        b        = 16'h0;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        check("reset_state", {11'h0, u_if1.ready, u_if1.busy, u_if1.done, u_if1.zr, u_if1.ng, u_if1.product},
              {11'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0});

        run_op(16'h0003, 16'h0005, 16'h000F, 1'b0, 1'b0, 7, 33, 1'b1);
        run_op(16'h1234, 16'h0000, 16'h0000, 1'b1, 1'b0, 3, 33, 1'b1);
        run_op(16'hFFFD, 16'h0007, 16'hFFEB, 1'b0, 1'b1, 7, 33, 1'b1);
        run_op(16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 33, 33, 1'b1);

        // Busy handling: pulses in DBL and DONE ignored, then start held
        // into the following IDLE cycle is accepted.
        wait_ready();
        start = 1'b1; a = 16'd2; b = 16'd3;
        @(negedge clk);                              // k=1, ADD
        start = 1'b0;
        @(negedge clk);                              // k=2, DBL
        check("busy_in_dbl", {31'h0, u_if1.busy}, 32'h1);
        start = 1'b1; a = 16'd9; b = 16'd9;
        @(negedge clk);                              // k=3
        start = 1'b0;
        @(negedge clk);                              // k=4
        @(negedge clk);                              // k=5, DONE
        check("done_at_5", {31'h0, u_if1.done}, 32'h1);
        start = 1'b1; a = 16'd9; b = 16'd9;
        @(negedge clk);                              // k=6, IDLE
        check("prod_2x3", {16'h0, u_if1.product}, 32'h0006);
        check("ready_after_done", {31'h0, u_if1.ready}, 32'h1);
        a = 16'd4; b = 16'd4;
        @(negedge clk);                              // accepted
        start = 1'b0;
        check("held_start_accept", {31'h0, u_if1.busy}, 32'h1);
        seen_done = 0;
        for (int k = 0; k < 20; k++) begin
            if (u_if1.done) begin seen_done = 1; break; end
            @(negedge clk);
        end
        check("held_done_seen", seen_done, 1);
        @(negedge clk);
        check("prod_4x4", {16'h0, u_if1.product}, 32'h0010);

        // Reset in the middle of a long operation.
        wait_ready();
        start = 1'b1; a = 16'h0101; b = 16'h8000;
        @(negedge clk);                              // k=1
        start = 1'b0;
        seen_done = 0;
        for (int k = 2; k <= 9; k++) begin
            @(negedge clk);
            if (u_if1.done || u_if0.done) seen_done = 1;
        end
        rst_n = 1'b0;                                // sampled by edge 10
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_mid_status", {29'h0, u_if1.ready, u_if1.busy, u_if0.ready},
              {29'h0, 1'b1, 1'b0, 1'b1});
        check("rst_mid_product", {16'h0, u_if1.product}, 32'h0);
        for (int k = 0; k < 5; k++) begin
            if (u_if1.done || u_if0.done) seen_done = 1;
            @(negedge clk);
        end
        check("rst_no_done", seen_done, 0);
        run_op(16'd6, 16'd7, 16'h002A, 1'b0, 1'b0, 7, 33, 1'b1);

        // Random operations; multiplier width varied to exercise early exit.
        for (int t = 0; t < 30; t++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            bits = $urandom_range(0, 16);
            ra = 16'($urandom);
            rb = 16'($urandom) & 16'((32'h1 << bits) - 1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_op(ra, rb, 16'h0, 1'b0, 1'b0, 0, 0, 1'b0);
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
